mlp_sequencer: RTL and testbench

MLP_SEQUENCER -- requirements
Module: mlp_sequencer

---
 rtl/mlp_sequencer_pkg.sv | 31 +++
 rtl/mlp_sequencer_if.sv | 16 +
 rtl/mlp_sequencer_mac.sv | 42 ++++
 rtl/mlp_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mlp_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_sequencer_pkg.sv
// mlp_pkg: shared definitions for the two-layer MLP sequencer.
//   DATA_W          - width of features, weights, hidden values and scores
//   N_*_DEF         - default layer sizes
//   state_e         - sequencer state encoding
//   sat8()          - clamp a signed value to the signed 8-bit range
package mlp_pkg;

    localparam int DATA_W    = 8;
    localparam int N_IN_DEF  = 16;
    localparam int N_HID_DEF = 8;
    localparam int N_OUT_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        L1_MAC,
        L1_STORE,
        L2_MAC,
        L2_STORE,
        DONE
    } state_e;

    function automatic logic signed [DATA_W-1:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)
            return 8'h7f;
        else if (v < -32'sd128)
            return 8'h80;
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mlp_sequencer_if.sv
// mlp_sequencer_if: read bus between the sequencer and its feature buffer /
// weight ROM. Both memories return data one cycle after the address.
//   feat_addr / w_addr  - addresses driven by the sequencer (master)
//   feat_data / w_data  - signed data returned by the memories (slave)
interface mlp_sequencer_if #(
    parameter int FA_W = 4,
    parameter int WA_W = 8
);
    logic        [FA_W-1:0]           feat_addr;
    logic signed [mlp_pkg::DATA_W-1:0] feat_data;
    logic        [WA_W-1:0]           w_addr;
    logic signed [mlp_pkg::DATA_W-1:0] w_data;

    modport master (output feat_addr, output w_addr, input feat_data, input w_data);
    modport slave  (input feat_addr, input w_addr, output feat_data, output w_data);
endinterface

// File: rtl/mlp_sequencer_mac.sv
// mlp_mac: multiply-accumulate with requantization.
//   clk, rst_n      - clock, async active-low reset
//   a_i, b_i        - signed 8-bit operands
//   acc_en_i        - add a_i*b_i into the accumulator
//   fin_i           - clear the accumulator (result consumed this cycle)
//   relu_i          - clamp negative results to zero
//   res_o           - sat8((acc + a_i*b_i) >>> SHIFT), optionally ReLU'd
// res_o includes the current product so the final term never needs an
// extra cycle to land in the accumulator.
module mlp_mac import mlp_pkg::*; #(
    parameter int ACC_W = 20,
    parameter int SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic                     acc_en_i,
    input  logic                     fin_i,
    input  logic                     relu_i,
    output logic signed [DATA_W-1:0] res_o
);
    logic signed [ACC_W-1:0]    acc_q, acc_d, sum, shr;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   sat;

    always_comb begin
        acc_d = acc_q;
        prod  = 16'(a_i) * 16'(b_i);
        sum   = acc_q + ACC_W'(prod);
        shr   = sum >>> SHIFT;
        sat   = sat8(32'(shr));
        res_o = (relu_i && sat[DATA_W-1]) ? '0 : sat;
        if (acc_en_i) acc_d = sum;
        if (fin_i)    acc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
endmodule

// File: rtl/mlp_sequencer.sv
// mlp_sequencer: sequences a two-layer MLP inference (N_IN -> N_HID ReLU ->
// N_OUT) over an external feature buffer and weight ROM, then reports the
// argmax class and its score.
//   clk, reset_n           - clock, async active-low reset
//   start_mlp              - single-cycle request, honoured only in IDLE
//   feat_addr / feat_data  - feature buffer read (data one cycle later)
//   w_addr / w_data        - weight ROM read (data one cycle later); layer-1
//                            rows at j*N_IN+i, layer-2 rows after them
//   busy                   - high from acceptance through the valid cycle
//   mlp_valid_out          - one-cycle result strobe
//   class_out / score_out  - argmax result, held until the next result
module mlp_sequencer import mlp_pkg::*; #(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_HID = N_HID_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int SHIFT = 4
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     start_mlp,
    output logic [$clog2(N_IN)-1:0]                  feat_addr,
    input  logic signed [DATA_W-1:0]                 feat_data,
    output logic [$clog2(N_HID*N_IN+N_OUT*N_HID)-1:0] w_addr,
    input  logic signed [DATA_W-1:0]                 w_data,
    output logic                                     busy,
    output logic                                     mlp_valid_out,
    output logic [$clog2(N_OUT)-1:0]                 class_out,
    output logic signed [DATA_W-1:0]                 score_out
);
    localparam int FA_W    = $clog2(N_IN);
    localparam int WA_W    = $clog2(N_HID*N_IN+N_OUT*N_HID);
    localparam int HW      = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int CW      = $clog2(N_OUT);
    // Sized for the longer of the two dot products so neither can wrap.
    localparam int MAXN    = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int ACC_W   = 16 + $clog2(MAXN);
    localparam int L2_BASE = N_HID * N_IN;

    state_e                   st_q, st_d;
    logic [FA_W-1:0]          i_q, i_d;
    logic [HW-1:0]            j_q, j_d, m_q, m_d, mi_q, mi_d;
    logic [CW-1:0]            k_q, k_d;
    logic [N_HID-1:0][DATA_W-1:0] hid_q, hid_d;
    logic signed [DATA_W-1:0] max_q, max_d, score_q, score_d;
    logic [CW-1:0]            mcls_q, mcls_d, cls_q, cls_d;

    logic signed [DATA_W-1:0] mac_a, mac_res;
    logic                     acc_en, fin, relu, take;

    mlp_mac #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_mac (
        .clk      (clk),
        .rst_n    (reset_n),
        .a_i      (mac_a),
        .b_i      (w_data),
        .acc_en_i (acc_en),
        .fin_i    (fin),
        .relu_i   (relu),
        .res_o    (mac_res)
    );

    always_comb begin
        st_d      = st_q;
        i_d       = i_q;
        j_d       = j_q;
        m_d       = m_q;
        mi_d      = mi_q;
        k_d       = k_q;
        hid_d     = hid_q;
        max_d     = max_q;
        mcls_d    = mcls_q;
        cls_d     = cls_q;
        score_d   = score_q;
        feat_addr = '0;
        w_addr    = '0;
        mac_a     = feat_data;
        acc_en    = 1'b0;
        fin       = 1'b0;
        relu      = 1'b0;
        // Strictly greater keeps the lowest index on ties; output 0 seeds the max.
        take      = (k_q == '0) || (mac_res > max_q);

        case (st_q)
            IDLE: begin
                if (start_mlp) begin
                    st_d = L1_MAC;
                    i_d  = '0;
                    j_d  = '0;
                    m_d  = '0;
                    k_d  = '0;
                end
            end
            L1_MAC: begin
                feat_addr = i_q;
                w_addr    = WA_W'(32'(j_q) * N_IN + 32'(i_q));
                // Data for address i arrives at i+1; nothing is pending at i=0.
                acc_en    = (i_q != '0);
                if (i_q == FA_W'(N_IN-1)) begin
                    i_d  = '0;
                    st_d = L1_STORE;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            L1_STORE: begin
                fin        = 1'b1;
                relu       = 1'b1;
                hid_d[j_q] = mac_res;
                if (j_q == HW'(N_HID-1)) begin
                    j_d  = '0;
                    st_d = L2_MAC;
                end else begin
                    j_d  = j_q + 1'b1;
                    st_d = L1_MAC;
                end
            end
            L2_MAC: begin
                // mi_q trails m_q by one so the hidden operand lines up with w_data.
                mac_a  = $signed(hid_q[mi_q]);
                w_addr = WA_W'(L2_BASE + 32'(k_q) * N_HID + 32'(m_q));
                acc_en = (m_q != '0);
                mi_d   = m_q;
                if (m_q == HW'(N_HID-1)) begin
                    m_d  = '0;
                    st_d = L2_STORE;
                end else begin
                    m_d = m_q + 1'b1;
                end
            end
            L2_STORE: begin
                mac_a = $signed(hid_q[mi_q]);
                fin   = 1'b1;
                if (take) begin
                    max_d  = mac_res;
                    mcls_d = k_q;
                end
                if (k_q == CW'(N_OUT-1)) begin
                    k_d     = '0;
                    st_d    = DONE;
                    cls_d   = take ? k_q : mcls_q;
                    score_d = take ? mac_res : max_q;
                end else begin
                    k_d  = k_q + 1'b1;
                    st_d = L2_MAC;
                end
            end
            DONE:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            m_q     <= '0;
            mi_q    <= '0;
            k_q     <= '0;
            hid_q   <= '0;
            max_q   <= '0;
            mcls_q  <= '0;
            cls_q   <= '0;
            score_q <= '0;
        end else begin
            st_q    <= st_d;
            i_q     <= i_d;
            j_q     <= j_d;
            m_q     <= m_d;
            mi_q    <= mi_d;
            k_q     <= k_d;
            hid_q   <= hid_d;
            max_q   <= max_d;
            mcls_q  <= mcls_d;
            cls_q   <= cls_d;
            score_q <= score_d;
        end
    end

    assign busy          = (st_q != IDLE);
    assign mlp_valid_out = (st_q == DONE);
    assign class_out     = cls_q;
    assign score_out     = score_q;
endmodule

// File: tb/tb_mlp_sequencer.sv
// tb_mlp_sequencer: three sequencers (SHIFT = 0, 2, 4) share stimulus and
// memory contents; a reference model fills a per-instance scoreboard at each
// start and a monitor checks every valid strobe against it.
module tb_mlp_sequencer;
    import mlp_pkg::*;

    localparam int NI   = 16;
    localparam int NH   = 8;
    localparam int NO   = 4;
    localparam int NDUT = 3;
    localparam int NW   = NH*NI + NO*NH;
    localparam int FA_W = 4;
    localparam int WA_W = 8;
    localparam int CW   = 2;
    localparam int LAT  = NH*(NI+1) + NO*(NH+1) + 1;

    typedef struct packed {
        logic [CW-1:0] cls;
        logic [7:0]    score;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b1;
    logic start   = 1'b0;

    logic signed [7:0] feat_mem [NI];
    logic signed [7:0] w_mem    [NW];

    logic [NDUT-1:0]                busy, vld;
    logic [NDUT-1:0][CW-1:0]        cls;
    logic [NDUT-1:0][7:0]           score;
    logic [NDUT-1:0][FA_W-1:0]      fa;
    logic [NDUT-1:0][WA_W-1:0]      wa;
    logic [NDUT-1:0][NH-1:0][7:0]   hid;

    res_t sb_q [NDUT][$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_first [NDUT];
    int   m_nv    [NDUT];
    int   m_berr  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mlp_sequencer_if #(.FA_W(FA_W), .WA_W(WA_W)) bus ();
        mlp_sequencer #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .SHIFT(2*g)) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .start_mlp     (start),
            .feat_addr     (bus.feat_addr),
            .feat_data     (bus.feat_data),
            .w_addr        (bus.w_addr),
            .w_data        (bus.w_data),
            .busy          (busy[g]),
            .mlp_valid_out (vld[g]),
            .class_out     (cls[g]),
            .score_out     (score[g])
        );
        always @(posedge clk) begin
            bus.feat_data <= feat_mem[bus.feat_addr];
            bus.w_data    <= (int'(bus.w_addr) < NW) ? w_mem[bus.w_addr] : 8'sd0;
        end
        assign fa[g]  = bus.feat_addr;
        assign wa[g]  = bus.w_addr;
        assign hid[g] = u_dut.hid_q;
    end

    // ---------------- reference model ----------------
    function automatic int clamp(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int model_hid(input int sh, input int j);
        int acc = 0;
        int v;
        for (int i = 0; i < NI; i++) acc += int'(feat_mem[i]) * int'(w_mem[j*NI+i]);
        v = clamp(acc >>> sh);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic res_t model(input int sh);
        int   h [NH];
        int   acc, v, best;
        res_t r;
        for (int j = 0; j < NH; j++) h[j] = model_hid(sh, j);
        best = -1000;
        r = '0;
        for (int k = 0; k < NO; k++) begin
            acc = 0;
            for (int m = 0; m < NH; m++) acc += h[m] * int'(w_mem[NH*NI + k*NH + m]);
            v = clamp(acc >>> sh);
            if (v > best) begin
                best    = v;
                r.cls   = CW'(k);
                r.score = 8'(v);
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        res_t e;
        for (int g = 0; g < NDUT; g++) begin
            if (vld[g]) begin
                vectors++;
                if (sb_q[g].size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected dut%0d: valid strobe with no pending inference", g);
                end else begin
                    e = sb_q[g].pop_front();
                    if (cls[g] !== e.cls || score[g] !== e.score) begin
                        miscompares++;
                        $display("FAIL sb_result dut%0d: got class %0d score %0d, want class %0d score %0d",
                                 g, cls[g], $signed(score[g]), e.cls, $signed(e.score));
                    end
                end
            end
        end
    end

    // ---------------- stimulus utilities ----------------
    task automatic push_expected();
        for (int g = 0; g < NDUT; g++) sb_q[g].push_back(model(2*g));
    endtask

    task automatic start_pulse();
        start = 1'b1;
        push_expected();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_random(input bit full);
        for (int i = 0; i < NI; i++)
            feat_mem[i] = full ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 16)) - 8'd8;
        for (int i = 0; i < NW; i++)
            w_mem[i] = full ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 16)) - 8'd8;
    endtask

    task automatic drain(output bit ok);
        bit empty;
        ok = 1'b0;
        for (int c = 0; c < 4*LAT; c++) begin
            @(negedge clk);
            empty = 1'b1;
            for (int g = 0; g < NDUT; g++) if (sb_q[g].size() != 0) empty = 1'b0;
            if (empty) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Starts an inference at the current negedge and records, per instance,
    // the edge of the first valid strobe, the strobe count and busy errors.
    task automatic run_measure(input int re1, input int re2, input int ncyc);
        for (int g = 0; g < NDUT; g++) begin
            m_first[g] = -1;
            m_nv[g]    = 0;
            m_berr[g]  = 0;
        end
        start = 1'b1;
        push_expected();
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            start = 1'b0;
            for (int g = 0; g < NDUT; g++) begin
                if (vld[g]) begin
                    m_nv[g]++;
                    if (m_first[g] < 0) m_first[g] = n;
                end
                if (busy[g] !== (n <= LAT)) m_berr[g]++;
            end
            if (n == re1 || n == re2) start = 1'b1;
        end
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        start = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            vectors++; if (busy[g] !== 1'b0) begin miscompares++; $display("FAIL reset_busy dut%0d: got %0b want 0", g, busy[g]); end
            vectors++; if (vld[g] !== 1'b0)  begin miscompares++; $display("FAIL reset_valid dut%0d: got %0b want 0", g, vld[g]); end
            vectors++; if (cls[g] !== '0)    begin miscompares++; $display("FAIL reset_class dut%0d: got %0d want 0", g, cls[g]); end
            vectors++; if (score[g] !== '0)  begin miscompares++; $display("FAIL reset_score dut%0d: got %0d want 0", g, score[g]); end
            vectors++; if (fa[g] !== '0)     begin miscompares++; $display("FAIL reset_feat_addr dut%0d: got %0d want 0", g, fa[g]); end
            vectors++; if (wa[g] !== '0)     begin miscompares++; $display("FAIL reset_w_addr dut%0d: got %0d want 0", g, wa[g]); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            vectors++; if (fa[g] !== '0 || wa[g] !== '0) begin miscompares++; $display("FAIL idle_addr dut%0d: got feat %0d w %0d want 0/0", g, fa[g], wa[g]); end
        end
    endtask

    task automatic test_ones();
        bit ok;
        for (int i = 0; i < NI; i++) feat_mem[i] = 8'sd1;
        for (int i = 0; i < NW; i++) w_mem[i] = 8'sd1;
        start_pulse();
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ones_timeout: got no result, want result within budget"); end
        for (int g = 0; g < NDUT; g++)
            for (int j = 0; j < NH; j++) begin
                vectors++;
                if (hid[g][j] !== 8'(model_hid(2*g, j))) begin
                    miscompares++;
                    $display("FAIL ones_hidden dut%0d[%0d]: got %0d want %0d", g, j, hid[g][j], model_hid(2*g, j));
                end
            end
        // SHIFT=0: hidden 16 each, every score saturates to 127, tie -> class 0
        vectors++; if (hid[0][3] !== 8'd16) begin miscompares++; $display("FAIL ones_hidden16: got %0d want 16", hid[0][3]); end
        vectors++; if (cls[0] !== 2'd0 || score[0] !== 8'd127) begin
            miscompares++; $display("FAIL ones_sat: got class %0d score %0d want 0/127", cls[0], $signed(score[0]));
        end
    endtask

    task automatic test_relu();
        bit ok;
        for (int i = 0; i < NI; i++) feat_mem[i] = 8'sd1;
        for (int i = 0; i < NW; i++) w_mem[i] = (i < NH*NI) ? -8'sd1 : 8'($urandom_range(0, 255));
        start_pulse();
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL relu_timeout: got no result, want result within budget"); end
        for (int g = 0; g < NDUT; g++) begin
            vectors++; if (hid[g] !== '0) begin miscompares++; $display("FAIL relu_hidden dut%0d: got %h want 0", g, hid[g]); end
            vectors++; if (cls[g] !== '0 || score[g] !== '0) begin
                miscompares++; $display("FAIL relu_result dut%0d: got class %0d score %0d want 0/0", g, cls[g], $signed(score[g]));
            end
        end
    endtask

    task automatic test_ramp();
        bit ok;
        for (int i = 0; i < NI; i++) feat_mem[i] = 8'sd1;
        for (int i = 0; i < NH*NI; i++) w_mem[i] = 8'sd1;
        for (int k = 0; k < NO; k++)
            for (int m = 0; m < NH; m++) w_mem[NH*NI + k*NH + m] = 8'(k);
        start_pulse();
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ramp_timeout: got no result, want result within budget"); end
        // SHIFT=2: hidden 4, row k sums to 32k -> score 8k, highest row wins
        vectors++; if (hid[1][0] !== 8'd4) begin miscompares++; $display("FAIL ramp_hidden: got %0d want 4", hid[1][0]); end
        vectors++; if (cls[1] !== 2'd3 || score[1] !== 8'd24) begin
            miscompares++; $display("FAIL ramp_result: got class %0d score %0d want 3/24", cls[1], $signed(score[1]));
        end
    endtask

    task automatic test_timing();
        bit ok;
        fill_random(1'b0);
        run_measure(50, LAT, LAT + 60);
        for (int g = 0; g < NDUT; g++) begin
            vectors++; if (m_nv[g] !== 1)      begin miscompares++; $display("FAIL timing_count dut%0d: got %0d strobes want 1", g, m_nv[g]); end
            vectors++; if (m_first[g] !== LAT) begin miscompares++; $display("FAIL timing_latency dut%0d: got edge %0d want %0d", g, m_first[g], LAT); end
            vectors++; if (m_berr[g] !== 0)    begin miscompares++; $display("FAIL timing_busy dut%0d: got %0d bad cycles want 0", g, m_berr[g]); end
        end
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL timing_drain: got pending results, want none"); end
    endtask

    task automatic test_back_to_back();
        bit ok, seen;
        fill_random(1'b1);
        start_pulse();
        seen = 1'b0;
        for (int c = 0; c < 2*LAT && !seen; c++) begin
            @(negedge clk);
            if (vld[0]) seen = 1'b1;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_first: got no strobe, want one within budget"); end
        @(negedge clk);
        fill_random(1'b0);
        start_pulse();
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_drain: got pending results, want none"); end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 4; it++) begin
            fill_random(it[0]);
            start_pulse();
            drain(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL random_timeout it%0d: got pending results, want none", it); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nv;
        fill_random(1'b0);
        start = 1'b1;
        push_expected();
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        for (int g = 0; g < NDUT; g++) sb_q[g].delete();
        #1;
        for (int g = 0; g < NDUT; g++) begin
            vectors++;
            if (busy[g] !== 1'b0 || vld[g] !== 1'b0 || cls[g] !== '0 || score[g] !== '0 ||
                fa[g] !== '0 || wa[g] !== '0 || hid[g] !== '0) begin
                miscompares++;
                $display("FAIL midreset_clear dut%0d: got busy %0b vld %0b class %0d score %0d fa %0d wa %0d hid %h, want all 0",
                         g, busy[g], vld[g], cls[g], score[g], fa[g], wa[g], hid[g]);
            end
        end
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            nv += int'(vld != '0);
        end
        vectors++; if (nv !== 0) begin miscompares++; $display("FAIL midreset_novalid: got %0d strobes want 0", nv); end
        fill_random(1'b1);
        reset_n = 1'b1;
        run_measure(0, 0, LAT + 5);
        for (int g = 0; g < NDUT; g++) begin
            vectors++; if (m_first[g] !== LAT || m_nv[g] !== 1) begin
                miscompares++; $display("FAIL restart_latency dut%0d: got edge %0d count %0d want %0d/1", g, m_first[g], m_nv[g], LAT);
            end
        end
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL restart_drain: got pending results, want none"); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ones();
        test_relu();
        test_ramp();
        test_timing();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
